seq_sum_accum: RTL and testbench
================================

SEQ_SUM_ACCUM -- requirements
Module: seq_sum_accum

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 10, giving the operand and result width in bits; legal range is WIDTH >= 2.
REQ-003 The block SHALL have parameter COUNT, default 4, giving the number of accepted beats per frame; legal range is COUNT >= 1.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 clear  input  1  synchronous frame abort.
REQ-007 in_valid  input  1  operand beat offered.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 a  input  WIDTH  operand A, unsigned.
REQ-010 b  input  WIDTH  operand B, unsigned.
REQ-011 out_valid  output  1  frame result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out  output  WIDTH  frame sum.
REQ-014 ovf  output  1  sticky overflow flag for the current frame.
REQ-015 beat_cnt  output  CW  beats accepted in the current frame, where CW = max(1, $clog2(COUNT+1)).

Function
REQ-016 The FSM SHALL have two states, ACC and DONE.
- In ACC: in_ready=1 and out_valid=0.
- In DONE: in_ready=0 and out_valid=1.
REQ-017 A beat SHALL be accepted when in_ready and in_valid are both high at a rising clk edge.
REQ-018 On each accepted beat the accumulator SHALL update as follows.
- acc <= acc + a + b, computed at WIDTH+2 bits.
- The result is then reduced to WIDTH bits per REQ-031 or REQ-032.
- beat_cnt increments by 1.
REQ-019 ovf SHALL set when the WIDTH+2-bit sum exceeds 2^WIDTH-1, and SHALL remain set until the frame ends.
REQ-020 On acceptance of beat number COUNT, the FSM SHALL move to DONE on that same edge, so out_valid rises one cycle after the last accept.
REQ-021 In DONE, out and ovf SHALL stay stable until out_ready is sampled high.
REQ-022 When out_ready is sampled high in DONE, the next edge SHALL clear acc, beat_cnt and ovf to 0 and return the FSM to ACC.
REQ-023 The block SHALL NOT accept a beat in the same cycle as the DONE-to-ACC transition, because in_ready=0 in DONE.
REQ-024 out SHALL present acc in both states, so a partial sum is visible while in ACC.
REQ-025 When clear is high, the next edge SHALL force the state to ACC and set acc, beat_cnt and ovf to 0.
- clear has priority over a beat accept and over the out_ready handshake in the same cycle.
- Any such beat is discarded.
REQ-026 With COUNT=1, every accepted beat SHALL produce a result frame.
REQ-027 With in_valid low, ACC SHALL hold acc and beat_cnt unchanged.

Reset
REQ-028 Asserting rst SHALL immediately force state=ACC, acc=0, beat_cnt=0 and ovf=0, independent of clk.
REQ-029 Reset values of the outputs SHALL be in_ready=1, out_valid=0, out=0, ovf=0 and beat_cnt=0.
REQ-030 If rst is asserted mid-frame or during DONE, the partial or pending result SHALL be lost; the first edge after release behaves as a fresh frame.

Configuration
REQ-031 When macro SEQ_SUM_SAT_EN is defined, overflow SHALL saturate acc at 2^WIDTH-1.
- Once saturated, acc stays at 2^WIDTH-1 for the rest of the frame.
- ovf behaves per REQ-019.
REQ-032 When SEQ_SUM_SAT_EN is undefined, acc SHALL wrap modulo 2^WIDTH, and ovf SHALL still flag the overflow per REQ-019.

Verification (WIDTH=10, COUNT=2 unless stated)
REQ-033 Basic frame: accept beats (6,2) then (7,4), with out_ready=1 -> out=19 and out_valid high one cycle after the second accept, ovf=0, then return to ACC.
REQ-034 Backpressure: same beats, out_ready held low for 3 cycles -> out=19 is held and in_ready=0 throughout; a beat offered meanwhile is not accepted.
REQ-035 Overflow: beats (1000,20) then (5,5) -> ovf=1.
- With SEQ_SUM_SAT_EN defined: out=1023.
- With SEQ_SUM_SAT_EN undefined: out=6.
REQ-036 Clear: clear asserted together with the second beat (7,4) after (6,2) -> acc=0, beat_cnt=0 and no out_valid; the next frame (1,1),(1,1) gives out=4.
REQ-037 Reset mid-frame: rst pulsed between clk edges after beat (6,2) -> out=0 immediately; the next frame (3,3),(2,2) gives out=10.
REQ-038 COUNT=1: beat (500,12) -> out=512 with out_valid one cycle after the accept.

Source files
------------

// File: rtl/seq_sum_accum_if.sv
// ============================================================================
// Module  : seq_sum_accum_if
// Brief   : Operand/result bundle for seq_sum_accum (master = source/sink side)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_sum_accum_if #(
  parameter int WIDTH = 10,
  parameter int COUNT = 4
);
  localparam int CW = ($clog2(COUNT + 1) > 1) ? $clog2(COUNT + 1) : 1;

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ovf;
  logic [CW-1:0]    beat_cnt;

  modport master (
    output clear, in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, ovf, beat_cnt
  );

  modport slave (
    input  clear, in_valid, a, b, out_ready,
    output in_ready, out_valid, out, ovf, beat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/seq_sum_accum.sv
// ============================================================================
// Module  : seq_sum_accum
// Brief   : Accumulates a+b over COUNT accepted beats, presents the frame sum.
//           Define SEQ_SUM_SAT_EN to saturate on overflow instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_sum_accum #(
  parameter int WIDTH = 10,
  parameter int COUNT = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  seq_sum_accum_if.slave  bus
);

  localparam int CW = ($clog2(COUNT + 1) > 1) ? $clog2(COUNT + 1) : 1;
  localparam logic [CW-1:0]    c_last = CW'(COUNT - 1);
  localparam logic [WIDTH+1:0] c_max  = {2'b00, {WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH+1:0] w_sum;
  logic             w_over;
  logic [WIDTH-1:0] w_acc_next;

  // Two guard bits hold the worst case: (2^W-1)*3 < 2^(W+2).
  assign w_sum  = {2'b00, acc_q} + {2'b00, bus.a} + {2'b00, bus.b};
  assign w_over = (w_sum > c_max);

`ifdef SEQ_SUM_SAT_EN
  assign w_acc_next = w_over ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  assign w_acc_next = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    // clear outranks both the beat accept and the result handshake.
    if (bus.clear) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (bus.in_valid) begin
            acc_d = w_acc_next;
            cnt_d = cnt_q + CW'(1);
            ovf_d = ovf_q | w_over;
            if (cnt_q == c_last) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_ACC;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.beat_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_sum_accum.sv
// ============================================================================
// Module  : tb_seq_sum_accum
// Brief   : Directed self-checking bench for seq_sum_accum (COUNT=2 and COUNT=1)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_sum_accum;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seq_sum_accum_if #(.WIDTH(10), .COUNT(2)) b0 ();
  seq_sum_accum_if #(.WIDTH(10), .COUNT(1)) b1 ();

  seq_sum_accum #(.WIDTH(10), .COUNT(2)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  seq_sum_accum #(.WIDTH(10), .COUNT(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [9:0] av, input logic [9:0] bv);
    b0.in_valid = 1'b1;
    b0.a        = av;
    b0.b        = bv;
    tick();
    b0.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_ovf_out;
`ifdef SEQ_SUM_SAT_EN
    exp_ovf_out = 32'd1023;
`else
    exp_ovf_out = 32'd6;
`endif
    errors = 0;
    checks = 0;
    rst = 1'b1;
    b0.clear = 1'b0; b0.in_valid = 1'b0; b0.a = '0; b0.b = '0; b0.out_ready = 1'b1;
    b1.clear = 1'b0; b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.out_ready = 1'b1;

    #1;
    chk("rst_in_ready",  32'(b0.in_ready),  32'd1);
    chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_out",       32'(b0.out),       32'd0);
    chk("rst_ovf",       32'(b0.ovf),       32'd0);
    chk("rst_beat_cnt",  32'(b0.beat_cnt),  32'd0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    // Basic frame
    beat0(10'd6, 10'd2);
    chk("basic_partial",   32'(b0.out),       32'd8);
    chk("basic_cnt1",      32'(b0.beat_cnt),  32'd1);
    chk("basic_nv1",       32'(b0.out_valid), 32'd0);
    beat0(10'd7, 10'd4);
    chk("basic_out",       32'(b0.out),       32'd19);
    chk("basic_valid",     32'(b0.out_valid), 32'd1);
    chk("basic_inready0",  32'(b0.in_ready),  32'd0);
    chk("basic_ovf",       32'(b0.ovf),       32'd0);
    chk("basic_cnt2",      32'(b0.beat_cnt),  32'd2);
    tick();
    chk("basic_back_acc",  32'(b0.in_ready),  32'd1);
    chk("basic_back_out",  32'(b0.out),       32'd0);
    chk("basic_back_nv",   32'(b0.out_valid), 32'd0);

    // Backpressure: result held, offered beat ignored
    b0.out_ready = 1'b0;
    beat0(10'd6, 10'd2);
    beat0(10'd7, 10'd4);
    b0.in_valid = 1'b1; b0.a = 10'd100; b0.b = 10'd100;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out",      32'(b0.out),       32'd19);
      chk("bp_inready",  32'(b0.in_ready),  32'd0);
      chk("bp_valid",    32'(b0.out_valid), 32'd1);
      tick();
    end
    chk("bp_out_end",    32'(b0.out),       32'd19);
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b1;
    tick();
    chk("bp_release_out", 32'(b0.out),      32'd0);
    chk("bp_release_cnt", 32'(b0.beat_cnt), 32'd0);
    chk("bp_release_rdy", 32'(b0.in_ready), 32'd1);

    // Overflow
    beat0(10'd1000, 10'd20);
    chk("ovf_partial",   32'(b0.out),       32'd1020);
    chk("ovf_pre",       32'(b0.ovf),       32'd0);
    beat0(10'd5, 10'd5);
    chk("ovf_flag",      32'(b0.ovf),       32'd1);
    chk("ovf_out",       32'(b0.out),       exp_ovf_out);
    chk("ovf_valid",     32'(b0.out_valid), 32'd1);
    tick();
    chk("ovf_cleared",   32'(b0.ovf),       32'd0);

    // Clear beats the second beat
    beat0(10'd6, 10'd2);
    b0.clear = 1'b1;
    beat0(10'd7, 10'd4);
    b0.clear = 1'b0;
    chk("clr_acc",       32'(b0.out),       32'd0);
    chk("clr_cnt",       32'(b0.beat_cnt),  32'd0);
    chk("clr_nv",        32'(b0.out_valid), 32'd0);
    tick();
    chk("clr_nv2",       32'(b0.out_valid), 32'd0);
    beat0(10'd1, 10'd1);
    beat0(10'd1, 10'd1);
    chk("clr_next_out",  32'(b0.out),       32'd4);
    chk("clr_next_v",    32'(b0.out_valid), 32'd1);
    tick();

    // Hold with in_valid low, then async reset mid-frame
    beat0(10'd6, 10'd2);
    tick();
    chk("hold_out",      32'(b0.out),       32'd8);
    chk("hold_cnt",      32'(b0.beat_cnt),  32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out",      32'(b0.out),       32'd0);
    chk("arst_cnt",      32'(b0.beat_cnt),  32'd0);
    #1 rst = 1'b0;
    tick();
    beat0(10'd3, 10'd3);
    beat0(10'd2, 10'd2);
    chk("arst_next_out", 32'(b0.out),       32'd10);
    chk("arst_next_v",   32'(b0.out_valid), 32'd1);
    tick();

    // COUNT=1: every beat is a frame
    b1.in_valid = 1'b1; b1.a = 10'd500; b1.b = 10'd12;
    tick();
    b1.in_valid = 1'b0;
    chk("c1_out",        32'(b1.out),       32'd512);
    chk("c1_valid",      32'(b1.out_valid), 32'd1);
    chk("c1_cnt",        32'(b1.beat_cnt),  32'd1);
    tick();
    chk("c1_back",       32'(b1.out_valid), 32'd0);
    b1.in_valid = 1'b1; b1.a = 10'd1; b1.b = 10'd2;
    tick();
    b1.in_valid = 1'b0;
    chk("c1_out2",       32'(b1.out),       32'd3);
    chk("c1_valid2",     32'(b1.out_valid), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
